// File: rtl/camera_settings_ctrl.sv
// Camera settings controller: three debounced push-buttons select one of four
// settings (ISO, shutter, focal, indicator) and step its code up or down with
// saturation. All outputs are registered and feed a seven-segment controller.
module camera_settings_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] display_select,
    output logic [3:0] display_value,
    output logic [3:0] iso_value,
    output logic [3:0] shutter_value,
    output logic [3:0] focal_value,
    output logic [3:0] indicator_value,
    output logic       setting_changed
);

    localparam int unsigned NB = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 16;

    localparam logic [CW-1:0] ISO_MAX   = 4'd14;
    localparam logic [CW-1:0] SHUT_MAX  = 4'd15;
    localparam logic [CW-1:0] FOCAL_MAX = 4'd11;
    localparam logic [CW-1:0] IND_MAX   = 4'd5;

    localparam logic [CW-1:0] ISO_RST   = 4'd4;
    localparam logic [CW-1:0] SHUT_RST  = 4'd11;
    localparam logic [CW-1:0] FOCAL_RST = 4'd5;
    localparam logic [CW-1:0] IND_RST   = 4'd5;

    typedef enum logic [1:0] {
        S_ISO   = 2'b00,
        S_SHUT  = 2'b01,
        S_FOCAL = 2'b10,
        S_IND   = 2'b11
    } state_t;

    // Button bit order: 0 = mode, 1 = up, 2 = down
    logic [NB-1:0] w_btn_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_db_lvl;
    logic [NB-1:0] r_lvl_d;
    logic [NB-1:0] r_press;
    logic [DW-1:0] r_db_cnt [NB];
    logic [DW:0]   w_cnt_inc [NB];

    logic w_mode_p;
    logic w_up_p;
    logic w_down_p;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0] r_iso;
    logic [CW-1:0] r_shut;
    logic [CW-1:0] r_focal;
    logic [CW-1:0] r_ind;
    logic [CW-1:0] r_disp;
    logic          r_changed;

    logic [CW-1:0] w_iso_next;
    logic [CW-1:0] w_shut_next;
    logic [CW-1:0] w_focal_next;
    logic [CW-1:0] w_ind_next;
    logic [CW-1:0] w_disp_next;
    logic          w_changed;
    logic [CW-1:0] w_sel_code;
    logic [CW-1:0] w_sel_max;
    logic [CW-1:0] w_sel_new;
    logic          w_adjust;

    assign w_btn_raw = {btn_down, btn_up, btn_mode};

    // Two-flop synchronizer for the raw asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Widened counter increment so the terminal compare cannot overflow
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_cnt_inc[i] = {1'b0, r_db_cnt[i]} + 17'd1;
        end
    end

    // Per-button debouncer: level follows input after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_lvl <= '0;
            for (int i = 0; i < NB; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] != r_db_lvl[i]) begin
                    if (w_cnt_inc[i] == {1'b0, DEBOUNCE_CYCLES}) begin
                        r_db_lvl[i] <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= w_cnt_inc[i][DW-1:0];
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press pulse on each rising edge of a debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_d <= '0;
            r_press <= '0;
        end else begin
            r_lvl_d <= r_db_lvl;
            r_press <= r_db_lvl & ~r_lvl_d;
        end
    end

    assign w_mode_p = r_press[0];
    assign w_up_p   = r_press[1];
    assign w_down_p = r_press[2];

    // Selection state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mode pulse cycles the selection; otherwise hold
    always_comb begin
        w_state_next = r_state;
        if (w_mode_p) begin
            case (r_state)
                S_ISO:   w_state_next = S_SHUT;
                S_SHUT:  w_state_next = S_FOCAL;
                S_FOCAL: w_state_next = S_IND;
                S_IND:   w_state_next = S_ISO;
                default: w_state_next = S_ISO;
            endcase
        end
    end

    // Saturating step of the selected code; mode wins, up+down together cancel
    always_comb begin
        w_iso_next   = r_iso;
        w_shut_next  = r_shut;
        w_focal_next = r_focal;
        w_ind_next   = r_ind;
        w_sel_code   = r_iso;
        w_sel_max    = ISO_MAX;
        w_disp_next  = r_iso;

        case (r_state)
            S_ISO:   begin w_sel_code = r_iso;   w_sel_max = ISO_MAX;   end
            S_SHUT:  begin w_sel_code = r_shut;  w_sel_max = SHUT_MAX;  end
            S_FOCAL: begin w_sel_code = r_focal; w_sel_max = FOCAL_MAX; end
            default: begin w_sel_code = r_ind;   w_sel_max = IND_MAX;   end
        endcase

        w_adjust  = !w_mode_p && (w_up_p ^ w_down_p);
        w_sel_new = w_sel_code;
        if (w_adjust) begin
            if (w_up_p && (w_sel_code < w_sel_max)) begin
                w_sel_new = w_sel_code + 4'd1;
            end else if (w_down_p && (w_sel_code != 4'd0)) begin
                w_sel_new = w_sel_code - 4'd1;
            end
        end

        case (r_state)
            S_ISO:   w_iso_next   = w_sel_new;
            S_SHUT:  w_shut_next  = w_sel_new;
            S_FOCAL: w_focal_next = w_sel_new;
            default: w_ind_next   = w_sel_new;
        endcase

        case (w_state_next)
            S_ISO:   w_disp_next = w_iso_next;
            S_SHUT:  w_disp_next = w_shut_next;
            S_FOCAL: w_disp_next = w_focal_next;
            default: w_disp_next = w_ind_next;
        endcase

        w_changed = (w_state_next != r_state) || (w_sel_new != w_sel_code);
    end

    // Registered codes, display mux and change pulse, all updated on one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iso     <= ISO_RST;
            r_shut    <= SHUT_RST;
            r_focal   <= FOCAL_RST;
            r_ind     <= IND_RST;
            r_disp    <= ISO_RST;
            r_changed <= 1'b0;
        end else begin
            r_iso     <= w_iso_next;
            r_shut    <= w_shut_next;
            r_focal   <= w_focal_next;
            r_ind     <= w_ind_next;
            r_disp    <= w_disp_next;
            r_changed <= w_changed;
        end
    end

    assign display_select  = 2'(r_state);
    assign display_value   = r_disp;
    assign iso_value       = r_iso;
    assign shutter_value   = r_shut;
    assign focal_value     = r_focal;
    assign indicator_value = r_ind;
    assign setting_changed = r_changed;

endmodule

// File: tb/tb_camera_settings_ctrl.sv
// Self-checking bench for camera_settings_ctrl with a short debounce.
module tb_camera_settings_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] display_select;
    logic [3:0] display_value;
    logic [3:0] iso_value;
    logic [3:0] shutter_value;
    logic [3:0] focal_value;
    logic [3:0] indicator_value;
    logic       setting_changed;

    camera_settings_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_mode        (btn_mode),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .display_select  (display_select),
        .display_value   (display_value),
        .iso_value       (iso_value),
        .shutter_value   (shutter_value),
        .focal_value     (focal_value),
        .indicator_value (indicator_value),
        .setting_changed (setting_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int code [4];
    } exp_t;

    exp_t sb_q [$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   chg_count = 0;
    int   last_chg_cyc = 0;
    int   press_cyc = 0;

    int   m_sel;
    int   m_code [4];
    int   max_v  [4] = '{14, 15, 11, 5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_sel = 0;
        m_code[0] = 4; m_code[1] = 11; m_code[2] = 5; m_code[3] = 5;
    endtask

    task automatic push_exp();
        exp_t e;
        e.sel = m_sel;
        for (int i = 0; i < 4; i++) e.code[i] = m_code[i];
        sb_q.push_back(e);
    endtask

    // mask bit 0 = mode, 1 = up, 2 = down
    task automatic press(input logic [2:0] mask, input int hold);
        bit chg = 0;
        if (mask[0]) begin
            m_sel = (m_sel + 1) % 4;
            chg = 1;
        end else if (mask[1] ^ mask[2]) begin
            if (mask[1] && m_code[m_sel] < max_v[m_sel]) begin
                m_code[m_sel]++; chg = 1;
            end else if (mask[2] && m_code[m_sel] > 0) begin
                m_code[m_sel]--; chg = 1;
            end
        end
        if (chg) push_exp();
        @(negedge clk);
        press_cyc = cyc;
        {btn_down, btn_up, btn_mode} = mask;
        repeat (hold) @(negedge clk);
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    // Scoreboard: each setting_changed pulse must match the oldest expectation
    always @(negedge clk) begin
        if (setting_changed) begin
            chg_count++;
            last_chg_cyc = cyc;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_change", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("select",    int'(display_select),  e.sel);
                check_eq("disp_val",  int'(display_value),   e.code[e.sel]);
                check_eq("iso",       int'(iso_value),       e.code[0]);
                check_eq("shutter",   int'(shutter_value),   e.code[1]);
                check_eq("focal",     int'(focal_value),     e.code[2]);
                check_eq("indicator", int'(indicator_value), e.code[3]);
            end
        end
    end

    initial begin
        int base;
        int lat;
        int rst_cyc;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_select",  int'(display_select),  0);
        check_eq("rst_value",   int'(display_value),   4);
        check_eq("rst_iso",     int'(iso_value),       4);
        check_eq("rst_shutter", int'(shutter_value),   11);
        check_eq("rst_focal",   int'(focal_value),     5);
        check_eq("rst_ind",     int'(indicator_value), 5);
        check_eq("rst_changed", int'(setting_changed), 0);

        // Bounce rejection
        base = chg_count;
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("bounce_no_change", chg_count - base, 0);
        check_eq("bounce_iso", int'(iso_value), 4);

        // Clean press and hold
        base = chg_count;
        press(3'b010, 50);
        check_eq("hold_one_pulse", chg_count - base, 1);
        lat = last_chg_cyc - press_cyc;
        check_eq("press_latency_ok", int'(lat >= 7 && lat <= 9), 1);
        check_eq("hold_iso", int'(iso_value), 5);

        // Mode wrap
        for (int i = 0; i < 4; i++) press(3'b001, 8);
        check_eq("wrap_select", int'(display_select), 0);

        // Saturation at indicator max, then one step down
        for (int i = 0; i < 3; i++) press(3'b001, 8);
        base = chg_count;
        press(3'b010, 8);
        press(3'b010, 8);
        check_eq("sat_up_no_change", chg_count - base, 0);
        check_eq("sat_ind_max", int'(indicator_value), 5);
        press(3'b100, 8);
        check_eq("ind_down", int'(indicator_value), 4);

        // Focal floor at 0
        for (int i = 0; i < 3; i++) press(3'b001, 8);
        for (int i = 0; i < 15; i++) press(3'b100, 8);
        check_eq("focal_floor", int'(focal_value), 0);

        // Up-down together ignored
        base = chg_count;
        press(3'b110, 8);
        check_eq("updown_ignored", chg_count - base, 0);

        // Mode and up in the same cycle: mode wins
        press(3'b011, 8);
        check_eq("prio_select", int'(display_select), 3);
        check_eq("prio_ind", int'(indicator_value), 4);
        check_eq("prio_focal", int'(focal_value), 0);

        // Reset mid-debounce with button held
        @(negedge clk);
        btn_down = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_cyc = cyc;
        check_eq("midrst_iso", int'(iso_value), 4);
        model_reset();
        m_code[0] = 3;
        push_exp();
        base = chg_count;
        repeat (30) @(negedge clk);
        check_eq("midrst_one_dec", chg_count - base, 1);
        lat = last_chg_cyc - rst_cyc;
        check_eq("midrst_latency_ok", int'(lat >= 7 && lat <= 9), 1);
        check_eq("midrst_iso_dec", int'(iso_value), 3);
        btn_down = 1'b0;
        repeat (12) @(negedge clk);

        // Drain with a bounded wait
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
